lsu_ram_ctrl: RTL and testbench
===============================

// Module: lsu_ram_ctrl
// PURPOSE
//  Load/store unit between the core execute stage and the word-wide data RAM
//  (1-cycle async-read, posedge-write, word-only). Converts RV32I LB/LH/LW/LBU/LHU/
//  SB/SH/SW into RAM cycles. Sub-word stores use a read-modify-write sequence.
//  Loads are byte-lane extracted and sign- or zero-extended.
// PARAMETERS
//  RAM_DEPTH  1024  words in the attached RAM; word index = ADDR[$clog2(RAM_DEPTH)+1:2]
//  XLEN       32    data width; fixed at 32 for RV32I
// PORTS
//  CLK       in   1            clock
//  RSTa      in   1            reset, synchronous, active-low
//  REQ       in   1            access request, sampled only while READY=1
//  WE        in   1            1=store, 0=load
//  FUNCT3    in   3            RV32I funct3 of the load/store
//  ADDR      in   32           byte address
//  WDATA     in   32           store data, right-aligned
//  READY     out  1            idle, can accept REQ this cycle
//  DONE      out  1            1-cycle pulse, access complete
//  RDATA     out  32           load result, valid while DONE=1, held afterwards
//  ERR       out  1            with DONE: misaligned/illegal access, nothing written
//  RAM_WR    out  1            RAM write enable
//  RAM_OE    out  1            RAM output enable
//  RAM_ADDR  out  $clog2(RAM_DEPTH)  RAM word address
//  RAM_DIN   out  32           RAM write data
//  RAM_DOUT  in   32           RAM read data (combinational from RAM_ADDR)
// BEHAVIOUR
//  FSM states: IDLE, LD, ST, RMW_RD, RMW_WR, RESP.
//  Reset (RSTa=0 at posedge): state=IDLE. Latched addr/funct3/wdata/RDATA=0.
//   DONE=ERR=RAM_WR=RAM_OE=0, RAM_ADDR=RAM_DIN=0, READY=1.
//  IDLE: READY=1. REQ=1 latches WE/FUNCT3/ADDR/WDATA, then goes to
//   LD (load), ST (SW), RMW_RD (SB/SH), or RESP with ERR=1 (error case).
//  LD: RAM_OE=1, RAM_WR=0, RAM_ADDR=latched index. RAM_DOUT lane is selected by
//   addr[1:0], extended, and registered into RDATA. Next state RESP.
//  ST: RAM_WR=1, RAM_DIN=wdata, RAM_OE=0 -> RESP.
//  RMW_RD: RAM_OE=1, RAM_DOUT registered into merge buffer -> RMW_WR.
//  RMW_WR: RAM_WR=1, RAM_DIN=buffer with byte lane addr[1:0] (SB) or
//   halfword addr[1] (SH) replaced by wdata[7:0]/[15:0] -> RESP.
//  RESP: DONE=1, READY=0, ERR per latched check -> IDLE.
//  Latency from REQ-accept edge to DONE high: load/SW 2 cycles, SB/SH 3,
//   error 1. Throughput: next REQ can be accepted in the cycle after RESP.
//  REQ while READY=0: ignored, not queued. RAM_WR and RAM_OE are never
//   both 1. Both are 0 outside LD/ST/RMW_*.
//  Extension: LB/LH sign-extend bit 7/15. LBU/LHU zero-extend. LW passes through.
//   Stores never modify RDATA.
//  Address bits above the RAM index are ignored; the address wraps modulo
//   RAM_DEPTH words.
//  Reset mid-access: FSM aborts to IDLE with no DONE pulse. If reset coincides
//   with the RMW_WR or ST edge, the RAM write at that edge still commits,
//   because the RAM has no reset.
// CONFIGURATION
//  LSU_ALIGN_CHECK_EN defined:
//   - Error cases: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0;
//     funct3 011/110/111; store funct3 1xx.
//   - Any error case goes IDLE->RESP with ERR=1 and no RAM access. RDATA unchanged.
//  LSU_ALIGN_CHECK_EN undefined:
//   - ERR tied 0.
//   - Offending low address bits are forced to 0 (halfword: addr[0]; word: addr[1:0]).
//   - Illegal funct3 values execute as LW/SW.
// TESTING
//  1 SW 0x1000_0008=0xDEADBEEF, then LW 0x08 -> RAM_WR pulse at word 2,
//    DONE 2 cycles after accept, RDATA=0xDEADBEEF.
//  2 With word 2 holding 0xDEADBEEF: SB 0x0A data 0x55 -> 3-cycle RMW,
//    word=0xDE55BEEF. LB 0x0A -> 0x00000055. LBU 0x0B -> 0x000000DE.
//    LB 0x0B -> 0xFFFFFFDE.
//  3 SH 0x0E data 0x8001 over 0 -> word3=0x80010000. LH 0x0E -> 0xFFFF8001.
//    LHU 0x0E -> 0x00008001.
//  4 EN defined: LW 0x05 -> DONE+ERR 1 cycle after accept, no RAM_OE/RAM_WR,
//    RDATA unchanged. EN undefined: same request returns word 1, ERR=0.
//  5 REQ held high continuously with alternating accesses -> each accepted only
//    while READY=1, no extra RAM_WR, DONE count equals accept count.
//  6 RSTa=0 during RMW_RD of SB -> no DONE, RAM word unchanged. Outputs
//    at reset values, READY=1 on the next cycle.

Source files
------------

// File: rtl/lsu_ram_ctrl.sv
// Load/store unit converting RV32I loads/stores into cycles on a word-wide async-read RAM.
// Optional LSU_ALIGN_CHECK_EN: flag misaligned/illegal accesses with ERR instead of coercing them.
module lsu_ram_ctrl #(
    parameter int RAM_DEPTH = 1024,
    parameter int XLEN      = 32
) (
    input  logic                         CLK,
    input  logic                         RSTa,
    input  logic                         REQ,
    input  logic                         WE,
    input  logic [2:0]                   FUNCT3,
    input  logic [31:0]                  ADDR,
    input  logic [XLEN-1:0]              WDATA,
    output logic                         READY,
    output logic                         DONE,
    output logic [XLEN-1:0]              RDATA,
    output logic                         ERR,
    output logic                         RAM_WR,
    output logic                         RAM_OE,
    output logic [$clog2(RAM_DEPTH)-1:0] RAM_ADDR,
    output logic [XLEN-1:0]              RAM_DIN,
    input  logic [XLEN-1:0]              RAM_DOUT
);

    localparam int AW = $clog2(RAM_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LD, S_ST, S_RMW_RD, S_RMW_WR, S_RESP} state_t;

    state_t          state;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic [XLEN-1:0] wdata_q;

    logic [2:0]      dec_funct3;
    logic [1:0]      dec_off;
    logic            dec_err;
    logic            unused_addr;

    // Address bits above the RAM index are deliberately dropped so accesses wrap.
    assign unused_addr = ^ADDR[31:AW+2];

    always_comb begin
        dec_funct3 = FUNCT3;
        dec_off    = ADDR[1:0];
        dec_err    = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        if (WE) begin
            case (FUNCT3)
                3'b000:  dec_err = 1'b0;
                3'b001:  dec_err = ADDR[0];
                3'b010:  dec_err = |ADDR[1:0];
                default: dec_err = 1'b1;
            endcase
        end else begin
            case (FUNCT3)
                3'b000, 3'b100: dec_err = 1'b0;
                3'b001, 3'b101: dec_err = ADDR[0];
                3'b010:         dec_err = |ADDR[1:0];
                default:        dec_err = 1'b1;
            endcase
        end
`else
        // Without checking, illegal encodings become full-word accesses and low bits are masked.
        if (WE) begin
            case (FUNCT3)
                3'b000:  dec_off = ADDR[1:0];
                3'b001:  dec_off = {ADDR[1], 1'b0};
                default: begin
                    dec_funct3 = 3'b010;
                    dec_off    = 2'b00;
                end
            endcase
        end else begin
            case (FUNCT3)
                3'b000, 3'b100: dec_off = ADDR[1:0];
                3'b001, 3'b101: dec_off = {ADDR[1], 1'b0};
                default: begin
                    dec_funct3 = 3'b010;
                    dec_off    = 2'b00;
                end
            endcase
        end
`endif
    end

    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word,
                                                input logic [2:0] f3, input logic [1:0] off);
        logic [XLEN-1:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  extract = {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b001:  extract = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b100:  extract = {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b101:  extract = {{(XLEN-16){1'b0}}, sh[15:0]};
            default: extract = word;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] word, input logic [XLEN-1:0] data,
                                              input logic [2:0] f3, input logic [1:0] off);
        logic [XLEN-1:0] mask;
        logic [XLEN-1:0] ins;
        if (f3[0]) begin
            mask = XLEN'(32'h0000_FFFF) << {off[1], 4'b0000};
            ins  = XLEN'(data[15:0]) << {off[1], 4'b0000};
        end else begin
            mask = XLEN'(32'h0000_00FF) << {off, 3'b000};
            ins  = XLEN'(data[7:0]) << {off, 3'b000};
        end
        merge = (word & ~mask) | ins;
    endfunction

    // RAM_DIN doubles as the RMW merge buffer: the merged word is registered straight into it.
    always_ff @(posedge CLK) begin
        if (!RSTa) begin
            state    <= S_IDLE;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
            wdata_q  <= '0;
            RDATA    <= '0;
            READY    <= 1'b1;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            RAM_WR   <= 1'b0;
            RAM_OE   <= 1'b0;
            RAM_ADDR <= '0;
            RAM_DIN  <= '0;
        end else begin
            DONE   <= 1'b0;
            ERR    <= 1'b0;
            RAM_WR <= 1'b0;
            RAM_OE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (REQ) begin
                        funct3_q <= dec_funct3;
                        off_q    <= dec_off;
                        wdata_q  <= WDATA;
                        RAM_ADDR <= ADDR[AW+1:2];
                        READY    <= 1'b0;
                        if (dec_err) begin
                            state <= S_RESP;
                            DONE  <= 1'b1;
                            ERR   <= 1'b1;
                        end else if (!WE) begin
                            state  <= S_LD;
                            RAM_OE <= 1'b1;
                        end else if (dec_funct3 == 3'b010) begin
                            state   <= S_ST;
                            RAM_WR  <= 1'b1;
                            RAM_DIN <= WDATA;
                        end else begin
                            state  <= S_RMW_RD;
                            RAM_OE <= 1'b1;
                        end
                    end
                end
                S_LD: begin
                    RDATA <= extract(RAM_DOUT, funct3_q, off_q);
                    DONE  <= 1'b1;
                    state <= S_RESP;
                end
                S_ST: begin
                    DONE  <= 1'b1;
                    state <= S_RESP;
                end
                S_RMW_RD: begin
                    RAM_DIN <= merge(RAM_DOUT, wdata_q, funct3_q, off_q);
                    RAM_WR  <= 1'b1;
                    state   <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    DONE  <= 1'b1;
                    state <= S_RESP;
                end
                S_RESP: begin
                    READY <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    READY <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Self-checking bench for lsu_ram_ctrl: directed, randomized, back-to-back and mid-access reset.
// Expectations follow LSU_ALIGN_CHECK_EN the same way the design does.
module tb_lsu_ram_ctrl;

    localparam int DEPTH = 1024;

    logic        CLK = 1'b0;
    logic        RSTa = 1'b0;
    logic        REQ = 1'b0;
    logic        WE = 1'b0;
    logic [2:0]  FUNCT3 = 3'b000;
    logic [31:0] ADDR = '0;
    logic [31:0] WDATA = '0;
    logic        READY, DONE, ERR, RAM_WR, RAM_OE;
    logic [31:0] RDATA, RAM_DIN, RAM_DOUT;
    logic [9:0]  RAM_ADDR;

    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_rdata = '0;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int oe_cnt = 0;
    int both_cnt = 0;
    int done_cnt = 0;

    always #5 CLK = ~CLK;

    lsu_ram_ctrl #(.RAM_DEPTH(DEPTH), .XLEN(32)) dut (
        .CLK(CLK), .RSTa(RSTa), .REQ(REQ), .WE(WE), .FUNCT3(FUNCT3), .ADDR(ADDR), .WDATA(WDATA),
        .READY(READY), .DONE(DONE), .RDATA(RDATA), .ERR(ERR), .RAM_WR(RAM_WR), .RAM_OE(RAM_OE),
        .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN), .RAM_DOUT(RAM_DOUT)
    );

    // Attached RAM: async read, posedge write, no reset.
    always @(posedge CLK) if (RAM_WR) ram[RAM_ADDR] <= RAM_DIN;
    assign RAM_DOUT = ram[RAM_ADDR];

    always @(negedge CLK) begin
        if (RAM_WR) wr_cnt++;
        if (RAM_OE) oe_cnt++;
        if (RAM_WR && RAM_OE) both_cnt++;
        if (DONE) done_cnt++;
    end

    // Reference: access size/sign/error/offset derived from the RV32I rules.
    function automatic void ref_decode(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                       output int size, output bit sgn, output bit err, output int off);
        size = 4; sgn = 0; err = 0; off = int'(addr[1:0]);
        if (we) begin
            if (f3 == 3'd0) size = 1;
            else if (f3 == 3'd1) size = 2;
            else if (f3 != 3'd2) err = 1;
        end else begin
            case (f3)
                3'd0: begin size = 1; sgn = 1; end
                3'd1: begin size = 2; sgn = 1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: err = 1;
            endcase
        end
        if (size == 2 && (off % 2) != 0) err = 1;
        if (size == 4 && off != 0) err = 1;
`ifndef LSU_ALIGN_CHECK_EN
        err = 0;
        if (size == 2) off = off - (off % 2);
        if (size == 4) off = 0;
`endif
    endfunction

    task automatic ref_expect(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output int e_lat, output logic [31:0] e_rd,
                              output bit e_err, output int e_wr, output int e_oe);
        int size, off, idx;
        bit sgn, err;
        longint w, v, lowmask, mask;
        ref_decode(we, f3, addr, size, sgn, err, off);
        idx = int'((addr >> 2) % DEPTH);
        w = longint'(ref_mem[idx]);
        lowmask = (64'd1 << (8 * size)) - 1;
        e_wr = 0; e_oe = 0; e_lat = 1;
        if (!err && !we) begin
            v = (w >> (8 * off)) & lowmask;
            if (sgn && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
            exp_rdata = v[31:0];
            e_lat = 2; e_oe = 1;
        end else if (!err) begin
            mask = lowmask << (8 * off);
            v = (w & ~mask) | ((longint'(wdata) & lowmask) << (8 * off));
            ref_mem[idx] = v[31:0];
            e_wr = 1;
            e_lat = (size == 4) ? 2 : 3;
            e_oe = (size == 4) ? 0 : 1;
        end
        e_err = err;
        e_rd = exp_rdata;
    endtask

    // Drives one request and reports what the DUT did; the callers do the comparisons.
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                             output logic er, output logic [31:0] rd_after, output logic rdy_after,
                             output int wr_d, output int oe_d, output int both_d);
        int wr0, oe0, both0, waited;
        waited = 0;
        @(negedge CLK);
        while (!READY && waited < 10) begin
            @(negedge CLK);
            waited++;
        end
        wr0 = wr_cnt; oe0 = oe_cnt; both0 = both_cnt;
        REQ = 1'b1; WE = we; FUNCT3 = f3; ADDR = addr; WDATA = wdata;
        @(negedge CLK);
        REQ = 1'b0;
        lat = 1;
        while (!DONE && lat < 8) begin
            @(negedge CLK);
            lat++;
        end
        rd = RDATA;
        er = ERR;
        @(negedge CLK);
        rd_after = RDATA;
        rdy_after = READY;
        wr_d = wr_cnt - wr0;
        oe_d = oe_cnt - oe0;
        both_d = both_cnt - both0;
    endtask

    task automatic test_reset();
        RSTa = 1'b0;
        repeat (3) @(negedge CLK);
        RSTa = 1'b1;
        tests++; if (READY !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready got %b want 1", READY); end
        tests++; if (DONE !== 1'b0) begin fails++; $display("[TB] FAIL reset_done got %b want 0", DONE); end
        tests++; if (ERR !== 1'b0) begin fails++; $display("[TB] FAIL reset_err got %b want 0", ERR); end
        tests++; if (RAM_WR !== 1'b0 || RAM_OE !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_ram_ctl got wr=%b oe=%b want 0 0", RAM_WR, RAM_OE);
        end
        tests++; if (RAM_ADDR !== 10'd0 || RAM_DIN !== 32'd0) begin
            fails++; $display("[TB] FAIL reset_ram_bus got addr=%h din=%h want 0 0", RAM_ADDR, RAM_DIN);
        end
        tests++; if (RDATA !== 32'd0) begin fails++; $display("[TB] FAIL reset_rdata got %h want 0", RDATA); end
        exp_rdata = '0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic        exp_err;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[11];
        int lat, wr_d, oe_d, both_d, m_lat, m_wr, m_oe, e_wr, e_oe;
        logic [31:0] rd, rd_after, m_rd;
        logic er, rdy_after;
        bit m_err;
        vecs[0]  = '{1'b1, 3'b010, 32'h1000_0008, 32'hDEADBEEF, 32'h0000_0000, 2, 1'b0};
        vecs[1]  = '{1'b0, 3'b010, 32'h0000_0008, 32'h0,        32'hDEADBEEF, 2, 1'b0};
        vecs[2]  = '{1'b1, 3'b000, 32'h0000_000A, 32'h0000_0055, 32'hDEADBEEF, 3, 1'b0};
        vecs[3]  = '{1'b0, 3'b000, 32'h0000_000A, 32'h0,        32'h0000_0055, 2, 1'b0};
        vecs[4]  = '{1'b0, 3'b100, 32'h0000_000B, 32'h0,        32'h0000_00DE, 2, 1'b0};
        vecs[5]  = '{1'b0, 3'b000, 32'h0000_000B, 32'h0,        32'hFFFF_FFDE, 2, 1'b0};
        vecs[6]  = '{1'b1, 3'b001, 32'h0000_000E, 32'h0000_8001, 32'hFFFF_FFDE, 3, 1'b0};
        vecs[7]  = '{1'b0, 3'b001, 32'h0000_000E, 32'h0,        32'hFFFF_8001, 2, 1'b0};
        vecs[8]  = '{1'b0, 3'b101, 32'h0000_000E, 32'h0,        32'h0000_8001, 2, 1'b0};
        vecs[9]  = '{1'b1, 3'b010, 32'h0000_0004, 32'h1234_5678, 32'h0000_8001, 2, 1'b0};
`ifdef LSU_ALIGN_CHECK_EN
        vecs[10] = '{1'b0, 3'b010, 32'h0000_0005, 32'h0,        32'h0000_8001, 1, 1'b1};
`else
        vecs[10] = '{1'b0, 3'b010, 32'h0000_0005, 32'h0,        32'h1234_5678, 2, 1'b0};
`endif
        for (int i = 0; i < 11; i++) begin
            ref_expect(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, m_lat, m_rd, m_err, m_wr, m_oe);
            do_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                      lat, rd, er, rd_after, rdy_after, wr_d, oe_d, both_d);
            e_wr = (vecs[i].we && !vecs[i].exp_err) ? 1 : 0;
            e_oe = (!vecs[i].exp_err && (!vecs[i].we || vecs[i].f3 != 3'b010)) ? 1 : 0;
            tests++; if (rd !== vecs[i].exp_rd) begin
                fails++; $display("[TB] FAIL dir%0d_rdata got %h want %h", i, rd, vecs[i].exp_rd);
            end
            tests++; if (lat != vecs[i].exp_lat) begin
                fails++; $display("[TB] FAIL dir%0d_latency got %0d want %0d", i, lat, vecs[i].exp_lat);
            end
            tests++; if (er !== vecs[i].exp_err) begin
                fails++; $display("[TB] FAIL dir%0d_err got %b want %b", i, er, vecs[i].exp_err);
            end
            tests++; if (wr_d != e_wr || oe_d != e_oe || both_d != 0) begin
                fails++; $display("[TB] FAIL dir%0d_ram_ctl got wr=%0d oe=%0d both=%0d want %0d %0d 0",
                                  i, wr_d, oe_d, both_d, e_wr, e_oe);
            end
            tests++; if (rd_after !== vecs[i].exp_rd || rdy_after !== 1'b1) begin
                fails++; $display("[TB] FAIL dir%0d_hold got rdata=%h ready=%b want %h 1",
                                  i, rd_after, rdy_after, vecs[i].exp_rd);
            end
        end
        tests++; if (ram[2] !== 32'hDE55_BEEF) begin fails++; $display("[TB] FAIL dir_word2 got %h want de55beef", ram[2]); end
        tests++; if (ram[3] !== 32'h8001_0000) begin fails++; $display("[TB] FAIL dir_word3 got %h want 80010000", ram[3]); end
    endtask

    task automatic test_random();
        int lat, wr_d, oe_d, both_d, e_lat, e_wr, e_oe, idx;
        logic [31:0] rd, rd_after, e_rd, addr, wdata;
        logic er, rdy_after, we;
        logic [2:0] f3;
        bit e_err;
        for (int i = 0; i < 80; i++) begin
            addr = $urandom();
            addr[11:5] = 7'd0;
            wdata = $urandom();
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            idx = int'(addr[11:2]);
            ref_expect(we, f3, addr, wdata, e_lat, e_rd, e_err, e_wr, e_oe);
            do_access(we, f3, addr, wdata, lat, rd, er, rd_after, rdy_after, wr_d, oe_d, both_d);
            tests++; if (rd !== e_rd || er !== e_err || lat != e_lat) begin
                fails++; $display("[TB] FAIL rnd%0d_resp we=%b f3=%0d addr=%h got rd=%h err=%b lat=%0d want %h %b %0d",
                                  i, we, f3, addr, rd, er, lat, e_rd, e_err, e_lat);
            end
            tests++; if (wr_d != e_wr || oe_d != e_oe || both_d != 0) begin
                fails++; $display("[TB] FAIL rnd%0d_ram_ctl got wr=%0d oe=%0d both=%0d want %0d %0d 0",
                                  i, wr_d, oe_d, both_d, e_wr, e_oe);
            end
            tests++; if (ram[idx] !== ref_mem[idx] || rd_after !== e_rd || rdy_after !== 1'b1) begin
                fails++; $display("[TB] FAIL rnd%0d_state got word=%h rd=%h ready=%b want %h %h 1",
                                  i, ram[idx], rd_after, rdy_after, ref_mem[idx], e_rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        int accepts, stores, d0, w0, b0, waited, widx;
        logic [31:0] data;
        accepts = 0; stores = 0; waited = 0;
        @(negedge CLK);
        d0 = done_cnt; w0 = wr_cnt; b0 = both_cnt;
        REQ = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (READY) begin
                accepts++;
                widx = 4 + (accepts % 4);
                FUNCT3 = 3'b010;
                ADDR = 32'(widx * 4);
                if (accepts % 2 == 1) begin
                    data = $urandom();
                    WE = 1'b1; WDATA = data;
                    ref_mem[widx] = data;
                    stores++;
                end else begin
                    WE = 1'b0;
                end
            end else begin
                WE = 1'($urandom_range(0, 1));
                FUNCT3 = 3'($urandom_range(0, 7));
                ADDR = $urandom();
                WDATA = $urandom();
            end
            @(negedge CLK);
        end
        REQ = 1'b0;
        while (!READY && waited < 10) begin
            @(negedge CLK);
            waited++;
        end
        @(negedge CLK);
        tests++; if (done_cnt - d0 != accepts) begin
            fails++; $display("[TB] FAIL b2b_done_count got %0d want %0d", done_cnt - d0, accepts);
        end
        tests++; if (wr_cnt - w0 != stores || both_cnt != b0) begin
            fails++; $display("[TB] FAIL b2b_write_count got wr=%0d both=%0d want %0d 0",
                              wr_cnt - w0, both_cnt - b0, stores);
        end
        for (int k = 4; k < 8; k++) begin
            tests++; if (ram[k] !== ref_mem[k]) begin
                fails++; $display("[TB] FAIL b2b_word%0d got %h want %h", k, ram[k], ref_mem[k]);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int d0, w0, lat, wr_d, oe_d, both_d, e_lat, e_wr, e_oe, waited;
        logic [31:0] old, rd, rd_after, e_rd;
        logic er, rdy_after;
        bit e_err;
        waited = 0;
        @(negedge CLK);
        while (!READY && waited < 10) begin
            @(negedge CLK);
            waited++;
        end
        old = ram[6];
        d0 = done_cnt; w0 = wr_cnt;
        REQ = 1'b1; WE = 1'b1; FUNCT3 = 3'b000; ADDR = 32'h0000_0019; WDATA = 32'h0000_00AA;
        @(negedge CLK);
        REQ = 1'b0;
        tests++; if (RAM_OE !== 1'b1 || RAM_WR !== 1'b0) begin
            fails++; $display("[TB] FAIL mid_rmw_rd got oe=%b wr=%b want 1 0", RAM_OE, RAM_WR);
        end
        RSTa = 1'b0;
        @(negedge CLK);
        RSTa = 1'b1;
        exp_rdata = '0;
        tests++; if (READY !== 1'b1 || DONE !== 1'b0 || RAM_WR !== 1'b0 || RAM_OE !== 1'b0 || RDATA !== 32'd0) begin
            fails++; $display("[TB] FAIL mid_reset_outputs got ready=%b done=%b wr=%b oe=%b rdata=%h want 1 0 0 0 0",
                              READY, DONE, RAM_WR, RAM_OE, RDATA);
        end
        repeat (4) @(negedge CLK);
        tests++; if (done_cnt != d0 || wr_cnt != w0 || ram[6] !== old) begin
            fails++; $display("[TB] FAIL mid_no_effect got done=%0d wr=%0d word=%h want 0 0 %h",
                              done_cnt - d0, wr_cnt - w0, ram[6], old);
        end
        ref_expect(1'b0, 3'b010, 32'h0000_0018, 32'h0, e_lat, e_rd, e_err, e_wr, e_oe);
        do_access(1'b0, 3'b010, 32'h0000_0018, 32'h0, lat, rd, er, rd_after, rdy_after, wr_d, oe_d, both_d);
        tests++; if (rd !== e_rd || lat != e_lat) begin
            fails++; $display("[TB] FAIL mid_recover got rd=%h lat=%0d want %h %0d", rd, lat, e_rd, e_lat);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule
